// File: rtl/gated_reg_bank.sv
// Bank of CH independent WIDTH-bit registers with per-channel gate and clear,
// operating globally as plain flop, first-capture sticky, accumulator or shifter.
module gated_reg_bank #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   d,
    input  logic [CH-1:0]         g,
    input  logic [CH-1:0]         clr,
    input  logic [1:0]            mode,
    output logic [CH*WIDTH-1:0]   q,
    output logic [CH-1:0]         vld,
    output logic [CH-1:0]         ovf
);

    typedef enum logic [1:0] {
        MODE_FLOP   = 2'b00,
        MODE_STICKY = 2'b01,
        MODE_ACCUM  = 2'b10,
        MODE_SHIFT  = 2'b11
    } mode_e;

    mode_e mode_s;
    assign mode_s = mode_e'(mode);

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [WIDTH-1:0] d_s;
        logic [WIDTH-1:0] q_r;
        logic [WIDTH-1:0] q_nxt_s;
        logic [WIDTH:0]   sum_s;
        logic             vld_r;
        logic             vld_nxt_s;
        logic             ovf_r;
        logic             ovf_nxt_s;

        assign d_s   = d[k*WIDTH +: WIDTH];
        assign sum_s = {1'b0, q_r} + {1'b0, d_s};

        // Next-state for this channel; clear wins over gate, ovf only ever sets.
        always_comb begin
            q_nxt_s   = q_r;
            vld_nxt_s = vld_r;
            ovf_nxt_s = ovf_r;
            if (clr[k]) begin
                q_nxt_s   = {WIDTH{1'b0}};
                vld_nxt_s = 1'b0;
                ovf_nxt_s = 1'b0;
            end else if (g[k]) begin
                case (mode_s)
                    MODE_FLOP: begin
                        q_nxt_s   = d_s;
                        vld_nxt_s = 1'b1;
                    end
                    MODE_STICKY: begin
                        // vld doubles as the "already captured" arm bit
                        if (vld_r) begin
                            ovf_nxt_s = 1'b1;
                        end else begin
                            q_nxt_s   = d_s;
                            vld_nxt_s = 1'b1;
                        end
                    end
                    MODE_ACCUM: begin
                        q_nxt_s   = sum_s[WIDTH-1:0];
                        vld_nxt_s = 1'b1;
                        ovf_nxt_s = ovf_r | sum_s[WIDTH];
                    end
                    MODE_SHIFT: begin
                        q_nxt_s   = {q_r[WIDTH-2:0], d_s[0]};
                        vld_nxt_s = 1'b1;
                        ovf_nxt_s = ovf_r | q_r[WIDTH-1];
                    end
                    default: begin
                        q_nxt_s   = q_r;
                        vld_nxt_s = vld_r;
                        ovf_nxt_s = ovf_r;
                    end
                endcase
            end else begin
                q_nxt_s   = q_r;
                vld_nxt_s = vld_r;
                ovf_nxt_s = ovf_r;
            end
        end

        // Channel state register; async reset discards any partial accumulation.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_r   <= {WIDTH{1'b0}};
                vld_r <= 1'b0;
                ovf_r <= 1'b0;
            end else begin
                q_r   <= q_nxt_s;
                vld_r <= vld_nxt_s;
                ovf_r <= ovf_nxt_s;
            end
        end

        assign q[k*WIDTH +: WIDTH] = q_r;
        assign vld[k]              = vld_r;
        assign ovf[k]              = ovf_r;
    end

endmodule

// File: tb/tb_gated_reg_bank.sv
// Directed and model-checked stimulus for gated_reg_bank (WIDTH=8, CH=4).
module tb_gated_reg_bank;

    logic        clk;
    logic        rst_n;
    logic [31:0] d;
    logic [3:0]  g;
    logic [3:0]  clr;
    logic [1:0]  mode;
    logic [31:0] q;
    logic [3:0]  vld;
    logic [3:0]  ovf;

    int checks = 0;
    int errors = 0;

    int m_q [4];
    int m_v [4];
    int m_o [4];

    gated_reg_bank #(.WIDTH(8), .CH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .g     (g),
        .clr   (clr),
        .mode  (mode),
        .q     (q),
        .vld   (vld),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] eq, input logic [3:0] ev,
                           input logic [3:0] eo);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_vld"}, {28'd0, vld}, {28'd0, ev});
        chk({tag, "_ovf"}, {28'd0, ovf}, {28'd0, eo});
    endtask

    // Reference model update for one edge, written in integer arithmetic.
    task automatic model_edge();
        int dk;
        int s;
        for (int k = 0; k < 4; k++) begin
            dk = int'(d[k*8 +: 8]);
            if (clr[k]) begin
                m_q[k] = 0; m_v[k] = 0; m_o[k] = 0;
            end else if (g[k]) begin
                case (mode)
                    2'b00: begin m_q[k] = dk; m_v[k] = 1; end
                    2'b01: begin
                        if (m_v[k] == 1) m_o[k] = 1;
                        else begin m_q[k] = dk; m_v[k] = 1; end
                    end
                    2'b10: begin
                        s = m_q[k] + dk;
                        if (s > 255) m_o[k] = 1;
                        m_q[k] = s % 256;
                        m_v[k] = 1;
                    end
                    default: begin
                        if (m_q[k] >= 128) m_o[k] = 1;
                        m_q[k] = ((m_q[k] * 2) + (dk % 2)) % 256;
                        m_v[k] = 1;
                    end
                endcase
            end
        end
    endtask

    function automatic logic [31:0] model_q();
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = 8'(m_q[k]);
        return r;
    endfunction

    function automatic logic [3:0] model_bits(input int which);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 4; k++) r[k] = (which == 0) ? (m_v[k] == 1) : (m_o[k] == 1);
        return r;
    endfunction

    initial begin
        logic [7:0] sh;
        rst_n = 1'b0; d = 32'd0; g = 4'd0; clr = 4'd0; mode = 2'b00;
        #3;
        chk_all("reset", 32'd0, 4'b0000, 4'b0000);
        #4 rst_n = 1'b1;
        step();

        // Plain flop capture on ch0 only
        d = 32'h000000A5; g = 4'b0001; mode = 2'b00;
        step();
        chk_all("flop", 32'h000000A5, 4'b0001, 4'b0000);
        d = 32'hFFFFFFFF; g = 4'b0000;
        step();
        chk_all("hold", 32'h000000A5, 4'b0001, 4'b0000);

        // Sticky ch1: first capture kept, second flags overflow, clear resets
        mode = 2'b01; d = 32'h00001100; g = 4'b0010;
        step();
        chk_all("sticky1", 32'h000011A5, 4'b0011, 4'b0000);
        d = 32'h00002200;
        step();
        chk_all("sticky2", 32'h000011A5, 4'b0011, 4'b0010);
        clr = 4'b0010;
        step();
        chk_all("sticky_clr", 32'h000000A5, 4'b0001, 4'b0000);
        clr = 4'b0000;

        // Entering sticky with vld set: gated edge flags ovf, no capture
        d = 32'h00000077; g = 4'b0001;
        step();
        chk_all("sticky_armed", 32'h000000A5, 4'b0001, 4'b0001);
        mode = 2'b00; d = 32'h0000003C;
        step();
        chk_all("ovf_sticky", 32'h0000003C, 4'b0001, 4'b0001);

        // Accumulate ch2 with carry-out
        mode = 2'b10; g = 4'b0100; d = 32'h00F00000;
        step();
        chk_all("accum1", 32'h00F0003C, 4'b0101, 4'b0001);
        d = 32'h00200000;
        step();
        chk_all("accum2", 32'h0010003C, 4'b0101, 4'b0101);
        d = 32'h00010000;
        step();
        chk_all("accum3", 32'h0011003C, 4'b0101, 4'b0101);

        // Shift ones into ch3; ninth edge pushes out a 1
        mode = 2'b11; g = 4'b1000; d = 32'h01000000;
        sh = 8'h00;
        for (int i = 0; i < 9; i++) begin
            step();
            sh = {sh[6:0], 1'b1};
            chk("shift_q", q, {sh, 24'h11003C});
            chk("shift_ovf", {28'd0, ovf}, (i == 8) ? 32'h0000000D : 32'h00000005);
        end

        // Clear beats a simultaneous gate in accumulate
        g = 4'b0000; clr = 4'b0001;
        step();
        clr = 4'b0000; mode = 2'b10; g = 4'b0001; d = 32'h00000040;
        step();
        chk_all("acc40", 32'hFF110040, 4'b1101, 4'b1100);
        clr = 4'b0001;
        step();
        chk_all("clr_over_g", 32'hFF110000, 4'b1100, 4'b1100);
        clr = 4'b0000;

        // Async reset between edges with all channels nonzero
        mode = 2'b00; g = 4'b1111; d = 32'h11223344;
        step();
        chk_all("all_load", 32'h11223344, 4'b1111, 4'b1100);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 32'd0, 4'b0000, 4'b0000);
        step();
        chk_all("rst_ignores", 32'd0, 4'b0000, 4'b0000);
        #2 rst_n = 1'b1;
        g = 4'b0000;
        step();

        // Randomised traffic in each mode against the reference model
        for (int k = 0; k < 4; k++) begin m_q[k] = 0; m_v[k] = 0; m_o[k] = 0; end
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            for (int c = 0; c < 25; c++) begin
                d   = $urandom;
                g   = 4'($urandom_range(0, 15));
                clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
                model_edge();
                step();
                chk("rand_q", q, model_q());
                chk("rand_vld", {28'd0, vld}, {28'd0, model_bits(0)});
                chk("rand_ovf", {28'd0, ovf}, {28'd0, model_bits(1)});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
